// File: rtl/sga_game_controller.sv
// Snake Game Arcade control unit: sequences init, apple placement, render, tick wait, move, check and growth.
// Latency: Moore outputs valid the cycle after each state transition; render_count is gated combinationally by render_finish.
// Backpressure: RENDER waits on render_finish indefinitely; iniciar only acts in IDLE, END and WIN.
module sga_game_controller #(
  parameter int TICK_CYCLES = 1000,
  parameter int MAX_SIZE    = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] buttons,
  input  logic       render_finish,
  input  logic       apple_eaten,
  input  logic       collision,
  output logic       clear_size,
  output logic       count_size,
  output logic       render_clr,
  output logic       render_count,
  output logic       register_apple,
  output logic       reset_apple,
  output logic       move_step,
  output logic [1:0] direction,
  output logic       jogando,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [3:0]    SIZE_WIN  = 4'(MAX_SIZE);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_INIT        = 4'd1,
    S_PLACE_APPLE = 4'd2,
    S_RENDER_CLR  = 4'd3,
    S_RENDER      = 4'd4,
    S_WAIT_TICK   = 4'd5,
    S_MOVE        = 4'd6,
    S_CHECK       = 4'd7,
    S_GROW        = 4'd8,
    S_END         = 4'd9,
    S_WIN         = 4'd10
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tick;
  logic [3:0]      r_size;
  logic [3:0]      w_size_inc;
  logic            w_tick_last;
  logic [1:0]      r_dir;
  logic            r_pend_vld;
  logic [1:0]      r_pend_dir;
  logic            w_btn_vld;
  logic [1:0]      w_btn_dir;
  logic [1:0]      w_rev_dir;

  assign w_size_inc  = r_size + 4'd1;
  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_rev_dir   = r_dir ^ 2'b11;
  assign direction   = r_dir;
  assign db_estado   = r_state;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    w_next         = r_state;
    clear_size     = 1'b0;
    count_size     = 1'b0;
    render_clr     = 1'b0;
    render_count   = 1'b0;
    register_apple = 1'b0;
    reset_apple    = 1'b0;
    move_step      = 1'b0;
    jogando        = 1'b1;
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    case (r_state)
      S_IDLE: begin
        jogando = 1'b0;
        if (iniciar) w_next = S_INIT;
      end
      S_INIT: begin
        clear_size  = 1'b1;
        reset_apple = 1'b1;
        render_clr  = 1'b1;
        w_next      = S_PLACE_APPLE;
      end
      S_PLACE_APPLE: begin
        register_apple = 1'b1;
        w_next         = S_RENDER_CLR;
      end
      S_RENDER_CLR: begin
        render_clr = 1'b1;
        w_next     = S_RENDER;
      end
      S_RENDER: begin
        render_count = ~render_finish;
        if (render_finish) w_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (w_tick_last) w_next = S_MOVE;
      end
      S_MOVE: begin
        move_step = 1'b1;
        w_next    = S_CHECK;
      end
      S_CHECK: begin
        if (collision)        w_next = S_END;
        else if (apple_eaten) w_next = S_GROW;
        else                  w_next = S_RENDER_CLR;
      end
      S_GROW: begin
        count_size = 1'b1;
        w_next     = (w_size_inc == SIZE_WIN) ? S_WIN : S_PLACE_APPLE;
      end
      S_END: begin
        jogando = 1'b0;
        perdeu  = 1'b1;
        if (iniciar) w_next = S_INIT;
      end
      S_WIN: begin
        jogando = 1'b0;
        ganhou  = 1'b1;
        if (iniciar) w_next = S_INIT;
      end
      default: begin
        jogando = 1'b0;
        w_next  = S_IDLE;
      end
    endcase
  end

  // Tick counter: free-runs only in WAIT_TICK, wraps to 0 on the last cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick <= '0;
    end else if (r_state == S_INIT) begin
      r_tick <= '0;
    end else if (r_state == S_WAIT_TICK) begin
      r_tick <= w_tick_last ? '0 : r_tick + TW'(1);
    end
  end

  // Internal size copy, mirrors the datapath counter and saturates at the win length
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_size <= 4'd0;
    end else if (r_state == S_INIT) begin
      r_size <= 4'd1;
    end else if (r_state == S_GROW && r_size != SIZE_WIN) begin
      r_size <= w_size_inc;
    end
  end

  // Button priority: lowest index wins, and the index is the direction code
  always_comb begin
    w_btn_vld = |buttons;
    w_btn_dir = 2'b00;
    if (buttons[0])      w_btn_dir = 2'b00;
    else if (buttons[1]) w_btn_dir = 2'b01;
    else if (buttons[2]) w_btn_dir = 2'b10;
    else if (buttons[3]) w_btn_dir = 2'b11;
  end

  // Direction latch; a press on the edge entering MOVE is parked so that MOVE keeps the old heading
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dir      <= 2'b00;
      r_pend_vld <= 1'b0;
      r_pend_dir <= 2'b00;
    end else if (r_state == S_INIT) begin
      r_dir      <= 2'b00;
      r_pend_vld <= 1'b0;
    end else if (jogando) begin
      if (w_next == S_MOVE) begin
        if (w_btn_vld && w_btn_dir != w_rev_dir) begin
          r_pend_vld <= 1'b1;
          r_pend_dir <= w_btn_dir;
        end
      end else if (r_pend_vld) begin
        r_pend_vld <= 1'b0;
        if (r_pend_dir != w_rev_dir) r_dir <= r_pend_dir;
      end else if (w_btn_vld && w_btn_dir != w_rev_dir) begin
        r_dir <= w_btn_dir;
      end
    end else begin
      r_pend_vld <= 1'b0;
    end
  end

endmodule

// File: doc/sga_game_controller.md
# sga_game_controller

Control unit for the Snake Game Arcade. It sequences the game datapath through these phases: game initialisation, apple placement, frame render, move-tick wait, snake step, collision/apple check and growth. It also latches the player's direction from the four buttons. It drives the datapath's size counter, render counter and apple register, and consumes `render_finish`, `apple_eaten` and `collision`. The block sits beside the datapath under the game top level.

## Interface
Parameters:
- `TICK_CYCLES`, default 1000: clock cycles spent in WAIT_TICK per snake step. Must be ≥2.
- `MAX_SIZE`, default 15: snake length at which the game is won. Range 2..15.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high. Forces IDLE and clears all registers.
- `iniciar` in 1: start/restart request. Level, sampled each clock.
- `buttons` in 4: {left, down, up, right}, active-high, already debounced.
- `render_finish` in 1: datapath render counter equals snake size.
- `apple_eaten` in 1: head position equals apple position, valid in CHECK.
- `collision` in 1: head hit body or wall, valid in CHECK.
- `clear_size` out 1: synchronous clear of the size counter.
- `count_size` out 1: size counter increment.
- `render_clr` out 1: clear of the render counter.
- `render_count` out 1: render counter increment.
- `register_apple` out 1: load a new apple position.
- `reset_apple` out 1: clear the apple register.
- `move_step` out 1: datapath advances the snake one cell in `direction`.
- `direction` out 2: 00 right, 01 up, 10 down, 11 left.
- `jogando` out 1: high in every state except IDLE, END and WIN.
- `ganhou` out 1: high in WIN.
- `perdeu` out 1: high in END.
- `db_estado` out 4: current state code.

## Operation
- States and their codes: IDLE=0, INIT=1, PLACE_APPLE=2, RENDER_CLR=3, RENDER=4, WAIT_TICK=5, MOVE=6, CHECK=7, GROW=8, END=9, WIN=10. Codes 11-15 are unreachable and go to IDLE on the next clock.
- IDLE: when `iniciar`=1, go to INIT.
- INIT (1 cycle): assert `clear_size`, `reset_apple` and `render_clr`. Set `direction` to 00, the internal size copy to 1, and the tick counter to 0. Go to PLACE_APPLE.
- PLACE_APPLE (1 cycle): assert `register_apple`. Go to RENDER_CLR.
- RENDER_CLR (1 cycle): assert `render_clr`. Go to RENDER.
- RENDER: `render_count` = NOT `render_finish`. When `render_finish`=1, go to WAIT_TICK. The block has no timeout.
- WAIT_TICK: the tick counter runs 0..TICK_CYCLES-1. At TICK_CYCLES-1, clear the counter and go to MOVE.
- MOVE (1 cycle): assert `move_step`. Go to CHECK.
- CHECK (1 cycle): `collision` has priority and goes to END. Otherwise `apple_eaten` goes to GROW. Otherwise go to RENDER_CLR.
- GROW (1 cycle): assert `count_size` and increment the internal size. If the new size equals MAX_SIZE, go to WIN; otherwise go to PLACE_APPLE.
- END and WIN: hold. `iniciar`=1 goes to INIT; the game restarts with no pass through IDLE.
- `iniciar` is ignored in every other state; a started game cannot be restarted mid-play.
- Direction latch:
  - Update only while `jogando`=1.
  - Priority when several buttons are pressed: right > up > down > left (lowest index wins).
  - A press of the exact reverse of the current direction is ignored: 00↔11, 01↔10.
  - A new direction is used by the next MOVE, and the latch holds between presses.
- Internal size is 4 bits, saturating at MAX_SIZE. It mirrors the datapath size counter.

## Timing
- Reset values: state IDLE; every output 0; `direction`=00; `db_estado`=0; tick counter 0; internal size 0.
- All control outputs are Moore outputs decoded from the state register, except `render_count`, which is gated by `render_finish`. Outputs are valid in the cycle after the transition edge.
- Start latency: `iniciar` sampled at edge 0 gives INIT in cycle 1, PLACE_APPLE in cycle 2, RENDER_CLR in cycle 3, and RENDER from cycle 4.
- Render takes size+1 cycles in RENDER: size cycles of `render_count`, plus 1 cycle in which finish is seen.
- Step period without an apple = 1 (RENDER_CLR) + (size+1) + TICK_CYCLES + 1 (MOVE) + 1 (CHECK) cycles.
- A button sampled on the edge that enters MOVE is ignored by that MOVE. It applies from the next MOVE.
- Asynchronous `reset` mid-game returns to IDLE immediately. All outputs drop to 0 without waiting for a clock.

## Test plan
- Reset then idle: assert `reset` and hold `iniciar`=0 for 20 cycles. Required: `db_estado`=0 and all outputs 0 throughout.
- Start and first frame (TICK_CYCLES=4; datapath model sets `render_finish` when count=size=1): pulse `iniciar`. Required `db_estado` sequence: 1, 2, 3, 4, 4, 5, 5, 5, 5, 6, 7, 3. `render_count` is high for exactly 1 cycle.
- Direction: press up, then down in the same tick, then left. Required `direction` sequence: 01, then still 01 (down is a reverse and is ignored), then 11. Pressing up+left together gives 01.
- Apple growth: force `apple_eaten`=1 in CHECK. Required: GROW with `count_size` high for 1 cycle, then `register_apple`, then RENDER_CLR. Size is 2.
- Collision priority: force `collision`=1 and `apple_eaten`=1 in CHECK. Required: END, `perdeu`=1, no `count_size`. `iniciar` then gives INIT.
- Win with reset mid-game (MAX_SIZE=3): two apples give WIN and `ganhou`=1. Restart, then assert `reset` during WAIT_TICK. Required: state 0 and outputs 0 with no clock edge.
